uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter (byte-wide holding-register interface, txrdy status) between
//  NUM_REQ byte-stream requesters. Round-robin grant, held for a whole packet (req_last or
//  MAX_PKT bytes). Optionally prefixes each packet with a channel-ID header byte. Sits between
//  client logic and the UART core's tx_hold_reg / write-strobe / txrdy port (no-TX-FIFO config).
// PARAMETERS
//  NUM_REQ   4      number of requesters (2..8)
//  IDW       2      grant_id width, >= clog2(NUM_REQ)
//  HDR_EN    1      1 = emit header byte {HDR_BASE[7:3], id[2:0]} before each packet
//  HDR_BASE  8'hA0  header byte base value
//  MAX_PKT   16     max data bytes per grant (1..255); forced release at cap
// PORTS
//  clk        in   1          system clock
//  aresetn    in   1          asynchronous reset, active-low
//  req_valid  in   NUM_REQ    per-requester byte valid
//  req_data   in   8*NUM_REQ  per-requester byte; requester i on [8i+7:8i]
//  req_last   in   NUM_REQ    qualifies req_data as last byte of packet
//  req_ready  out  NUM_REQ    byte accepted when req_valid[i] & req_ready[i]
//  tx_data    out  8          byte to UART holding register (registered)
//  tx_wr      out  1          one-cycle write strobe to UART (registered)
//  txrdy      in   1          UART holding register empty (1 = may write)
//  grant_id   out  IDW        currently/last granted requester
//  busy       out  1          1 while state != IDLE
// BEHAVIOUR
//  Reset: tx_wr=0, tx_data=8'h00, req_ready=0, grant_id=0, busy=0, rr_ptr=0, byte_cnt=0,
//   state=IDLE. Reset mid-packet drops the packet silently; no tx_wr pulse issued afterwards.
//  States: IDLE, HDR, DATA, ACK.
//  IDLE: if any req_valid, grant first set bit at/after rr_ptr (wraps NUM_REQ-1 -> 0); latch
//   grant_id; byte_cnt=0; -> HDR (HDR_EN=1) or DATA. Arbitration costs exactly 1 cycle.
//  HDR: when txrdy=1: tx_wr<=1, tx_data<=HDR_BASE|grant_id, -> ACK (hdr flag set).
//  DATA: req_ready[grant_id] = txrdy (combinational, all others 0). On transfer: tx_wr<=1,
//   tx_data<=byte, byte_cnt++, capture last_seen = req_last | (byte_cnt+1 == MAX_PKT), -> ACK.
//   If req_valid[grant_id] drops, stay in DATA holding grant (no timeout).
//  ACK: tx_wr=0; wait for txrdy=0 (UART took byte; arrives 1 cycle after tx_wr). Then:
//   hdr flag -> DATA; last_seen -> rr_ptr<=grant_id+1 (mod NUM_REQ), -> IDLE; else -> DATA.
//  tx_wr is never asserted on two consecutive cycles; at most one byte in flight.
//  tx_data holds its value until the next write.
//  Requests from non-granted requesters are ignored (ready=0) until release.
//  MAX_PKT cap: release even without req_last; the remainder of that stream is a new packet
//   (new header) and competes normally.
//  byte_cnt 8-bit, saturation impossible (cleared on grant, bounded by MAX_PKT).
//  req_valid/req_data/req_last must be stable while valid & !ready (AXI-style rule).
// STRUCTURE
//  Include file uart_ctrl_defs.vh: state encodings (IDLE=0,HDR=1,DATA=2,ACK=3) and
//   header-format localparams, shared with future UART control blocks.
//  Sub-module uart_rr_arb: NUM_REQ request vector + rr_ptr -> one-hot grant + encoded id,
//   combinational; top holds the pointer, FSM, counters and output registers.
// TESTING
//  1 Req0 sends 3 bytes 11,22,33 (last on 33), HDR_EN=1 -> tx sequence A0,11,22,33; idle after.
//  2 Req1,Req2 both valid from reset, 2-byte packets -> A1,pkt1,A2,pkt2; then Req1 again
//   while Req3 valid -> Req3 served before Req1 (pointer wrap).
//  3 Req0 streams 20 bytes no last, MAX_PKT=16, Req2 waiting -> 16 bytes, A2+pkt2, A0+4 bytes.
//  4 Hold txrdy=1 for 5 cycles after tx_wr (slow UART) -> no second tx_wr until txrdy 0->1.
//  5 Granted requester deasserts valid 10 cycles mid-packet while Req3 valid -> grant held,
//   no Req3 bytes until release.
//  6 aresetn low while in ACK of byte 2 -> outputs to reset values same cycle; after release,
//   arbitration restarts at Req0; no spurious tx_wr.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings and the
// channel-ID header byte format.
package uart_tx_arbiter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_ACK  = 2'd3;

   localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

   // Header keeps the upper five base bits and carries the channel id below them.
   function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [2:0] id);
      return {base[7:3], id};
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the UART holding-register port, bundled for the arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_wr;
   logic                 txrdy;
   logic [IDW-1:0]       grant_id;
   logic                 busy;

   modport slave (
      input  req_valid, req_data, req_last, txrdy,
      output req_ready, tx_data, tx_wr, grant_id, busy
   );

   modport master (
      output req_valid, req_data, req_last, txrdy,
      input  req_ready, tx_data, tx_wr, grant_id, busy
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_arb.sv
// Combinational round-robin pick: first active request at or after ptr_i,
// wrapping from NUM_REQ-1 back to 0.
module uart_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDW-1:0]     id_o,
   output logic               any_o
);

   logic found;

   always_comb begin
      gnt_o = '0;
      id_o  = '0;
      any_o = |req_i;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_i[j] && (j == (int'(ptr_i) + k) % NUM_REQ)) begin
               found    = 1'b1;
               gnt_o[j] = 1'b1;
               id_o     = IDW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART holding register between NUM_REQ byte streams; the round-robin
// grant is held for a whole packet and each packet may be prefixed with an id header.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int         NUM_REQ  = 4,
   parameter int         IDW      = 2,
   parameter int         HDR_EN   = 1,
   parameter logic [7:0] HDR_BASE = HDR_BASE_DEF,
   parameter int         MAX_PKT  = 16
) (
   input  logic          clk,
   input  logic          aresetn,
   uart_tx_arbiter_if.slave bus
);

   logic [1:0]         state_q, state_d;
   logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]     gid_q, gid_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [7:0]         byte_cnt_q, byte_cnt_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_wr_q, tx_wr_d;
   logic               last_q, last_d;
   logic               hdr_q, hdr_d;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDW-1:0]     arb_id;
   logic               arb_any;
   logic               sel_valid, sel_last, xfer;
   logic [7:0]         sel_data;
   logic [IDW-1:0]     ptr_next;

   uart_rr_arb #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
      .req_i (bus.req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .id_o  (arb_id),
      .any_o (arb_any)
   );

   // The latched one-hot grant steers the byte mux and the ready fan-out.
   always_comb begin
      sel_data = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (gnt_q[j]) sel_data = sel_data | bus.req_data[8*j +: 8];
      end
   end

   assign sel_valid = |(bus.req_valid & gnt_q);
   assign sel_last  = |(bus.req_last & gnt_q);
   assign xfer      = (state_q == ST_DATA) && bus.txrdy && sel_valid;
   assign ptr_next  = (gid_q == IDW'(NUM_REQ - 1)) ? '0 : gid_q + IDW'(1);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gid_d      = gid_q;
      gnt_d      = gnt_q;
      byte_cnt_d = byte_cnt_q;
      tx_data_d  = tx_data_q;
      tx_wr_d    = 1'b0;
      last_d     = last_q;
      hdr_d      = hdr_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               gid_d      = arb_id;
               gnt_d      = arb_gnt;
               byte_cnt_d = '0;
               last_d     = 1'b0;
               state_d    = (HDR_EN != 0) ? ST_HDR : ST_DATA;
            end
         end
         ST_HDR: begin
            if (bus.txrdy) begin
               tx_wr_d   = 1'b1;
               tx_data_d = hdr_byte(HDR_BASE, 3'(gid_q));
               hdr_d     = 1'b1;
               state_d   = ST_ACK;
            end
         end
         ST_DATA: begin
            if (xfer) begin
               tx_wr_d    = 1'b1;
               tx_data_d  = sel_data;
               byte_cnt_d = byte_cnt_q + 8'd1;
               last_d     = sel_last || (byte_cnt_q + 8'd1 == 8'(MAX_PKT));
               hdr_d      = 1'b0;
               state_d    = ST_ACK;
            end
         end
         ST_ACK: begin
            // txrdy falling is the UART's proof that it took the byte.
            if (!bus.txrdy) begin
               if (hdr_q) begin
                  hdr_d   = 1'b0;
                  state_d = ST_DATA;
               end else if (last_q) begin
                  rr_ptr_d = ptr_next;
                  state_d  = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         gid_q      <= '0;
         gnt_q      <= '0;
         byte_cnt_q <= '0;
         tx_data_q  <= '0;
         tx_wr_q    <= 1'b0;
         last_q     <= 1'b0;
         hdr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gid_q      <= gid_d;
         gnt_q      <= gnt_d;
         byte_cnt_q <= byte_cnt_d;
         tx_data_q  <= tx_data_d;
         tx_wr_q    <= tx_wr_d;
         last_q     <= last_d;
         hdr_q      <= hdr_d;
      end
   end

   assign bus.req_ready = ((state_q == ST_DATA) && bus.txrdy) ? gnt_q : '0;
   assign bus.tx_data   = tx_data_q;
   assign bus.tx_wr     = tx_wr_q;
   assign bus.grant_id  = gid_q;
   assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-stream requesters and a UART holding-register model
// driven from one process, with a queue-based round-robin packet model.
module tb_uart_tx_arbiter;

   localparam int         NR   = 4;
   localparam int         MAXP = 16;
   localparam logic [7:0] HB   = 8'hA0;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   typedef struct {
      int         id;
      int         len;
      bit         has_last;
      logic [7:0] base;
      int         exp_n;
      logic [7:0] exp_hdr;
      bit         exp_busy;
   } vec_t;

   logic clk = 1'b0;
   logic aresetn;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NR), .IDW(2)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ(NR), .IDW(2), .HDR_EN(1), .HDR_BASE(HB), .MAX_PKT(MAXP)
   ) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   beat_t      sq [NR][$];
   logic [7:0] got [$];
   logic [7:0] expq [$];
   int         wr_cyc [$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic [NR-1:0] pend_pop;
   int         popped [NR];
   bit         prev_wr, u_pend, rand_uart, rand_gaps;
   int         u_hold, u_busy, hold_cfg;
   int         gap_id, gap_after, gap_rem;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic env_clear();
      for (int i = 0; i < NR; i++) begin
         sq[i].delete();
         popped[i] = 0;
      end
      got.delete();
      wr_cyc.delete();
      pend_pop = '0;
      prev_wr = 1'b0; u_pend = 1'b0; u_hold = 0; u_busy = 0;
      hold_cfg = 0; rand_uart = 1'b0; rand_gaps = 1'b0;
      gap_id = 0; gap_after = 0; gap_rem = 0;
      bus.txrdy = 1'b1;
      bus.req_valid = '0;
      bus.req_last = '0;
      bus.req_data = '0;
   endtask

   // One clock of environment: retire accepted bytes, run the UART, drive requesters.
   task automatic step();
      logic [NR-1:0]   v, l;
      logic [8*NR-1:0] d;
      bit              gap;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NR; i++) begin
         if (pend_pop[i] && sq[i].size() > 0) begin
            sq[i].delete(0);
            popped[i]++;
         end
      end
      if (bus.tx_wr === 1'b1) begin
         chk("tx_wr_proto", {29'd0, prev_wr, u_pend, !bus.txrdy}, 32'd0);
         got.push_back(bus.tx_data);
         wr_cyc.push_back(cyc);
         u_pend = 1'b1;
         u_hold = hold_cfg;
      end else if (u_pend) begin
         if (u_hold > 0) u_hold--;
         else begin
            bus.txrdy = 1'b0;
            u_pend = 1'b0;
            u_busy = rand_uart ? int'($urandom_range(0, 3)) : 1;
         end
      end else if (bus.txrdy === 1'b0) begin
         if (u_busy > 0) u_busy--;
         else bus.txrdy = 1'b1;
      end
      prev_wr = (bus.tx_wr === 1'b1);
      v = '0; l = '0; d = '0;
      for (int i = 0; i < NR; i++) begin
         if (sq[i].size() > 0) begin
            gap = 1'b0;
            if (bus.busy === 1'b1 && int'(bus.grant_id) == i) begin
               if (gap_rem > 0 && i == gap_id && popped[i] == gap_after) begin
                  gap = 1'b1;
                  gap_rem--;
               end else if (rand_gaps && $urandom_range(0, 3) == 0) begin
                  gap = 1'b1;
               end
            end
            v[i] = !gap;
            l[i] = sq[i][0].l;
            d[8*i +: 8] = sq[i][0].d;
         end
      end
      bus.req_valid = v;
      bus.req_last = l;
      bus.req_data = d;
      #1;
      pend_pop = bus.req_valid & bus.req_ready;
      chk("ready_only_to_grant", 32'(bus.req_ready & ~(4'b0001 << bus.grant_id)), 32'd0);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      env_clear();
      repeat (3) step();
      aresetn = 1'b1;
   endtask

   task automatic load_pkt(input int id, input int len, input logic [7:0] base, input bit has_last);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.d = base + 8'(k);
         b.l = has_last && (k == len - 1);
         sq[id].push_back(b);
      end
   endtask

   task automatic run_until(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (got.size() < n && k < budget) begin
         step();
         k++;
      end
      chk({name, "_done"}, 32'(got.size() >= n), 32'd1);
   endtask

   task automatic cmp_stream(input string name);
      chk({name, "_len"}, 32'(got.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size() && i < got.size(); i++)
         chk($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(expq[i]));
   endtask

   // Reference: every requester holds a queue of beats and is always ready to send;
   // pick round-robin, emit header then bytes until last or MAXP, advance past winner.
   task automatic model(input int start_ptr);
      beat_t m [NR][$];
      beat_t b;
      int    ptr, id, n;
      bit    found, stop;
      for (int i = 0; i < NR; i++) m[i] = sq[i];
      expq.delete();
      ptr = start_ptr;
      stop = 1'b0;
      while (!stop) begin
         found = 1'b0;
         id = 0;
         for (int k = 0; k < NR; k++) begin
            if (!found && m[(ptr + k) % NR].size() > 0) begin
               found = 1'b1;
               id = (ptr + k) % NR;
            end
         end
         if (!found) stop = 1'b1;
         else begin
            expq.push_back(8'((HB & 8'hF8) | 8'(id)));
            n = 0;
            do begin
               b = m[id].pop_front();
               expq.push_back(b.d);
               n++;
            end while (!b.l && n < MAXP && m[id].size() > 0);
            if (!b.l && n < MAXP) stop = 1'b1;
            ptr = (id + 1) % NR;
         end
      end
   endtask

   initial begin
      vec_t tbl [6];
      tbl[0] = '{1, 1,  1'b1, 8'h40, 2,  8'hA1, 1'b0};
      tbl[1] = '{2, 16, 1'b0, 8'h50, 17, 8'hA2, 1'b0};
      tbl[2] = '{3, 16, 1'b1, 8'h60, 17, 8'hA3, 1'b0};
      tbl[3] = '{0, 17, 1'b1, 8'h70, 19, 8'hA0, 1'b0};
      tbl[4] = '{1, 20, 1'b0, 8'h80, 22, 8'hA1, 1'b1};
      tbl[5] = '{3, 2,  1'b0, 8'h90, 3,  8'hA3, 1'b1};

      aresetn = 1'b0;
      env_clear();
      repeat (3) step();
      chk("rst_tx_wr", 32'(bus.tx_wr), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      aresetn = 1'b1;

      // Single requester, three bytes.
      do_reset();
      load_pkt(0, 1, 8'h11, 1'b0);
      load_pkt(0, 1, 8'h22, 1'b0);
      load_pkt(0, 1, 8'h33, 1'b1);
      expq = '{8'hA0, 8'h11, 8'h22, 8'h33};
      run_until(4, 200, "basic");
      repeat (8) step();
      cmp_stream("basic");
      chk("basic_idle", 32'(bus.busy), 32'd0);

      for (int t = 0; t < 6; t++) begin
         do_reset();
         load_pkt(tbl[t].id, tbl[t].len, tbl[t].base, tbl[t].has_last);
         run_until(tbl[t].exp_n, 60 * tbl[t].exp_n + 50, $sformatf("vec%0d", t));
         repeat (8) step();
         chk($sformatf("vec%0d_count", t), 32'(got.size()), 32'(tbl[t].exp_n));
         chk($sformatf("vec%0d_hdr", t), 32'(got[0]), 32'(tbl[t].exp_hdr));
         chk($sformatf("vec%0d_first", t), 32'(got[1]), 32'(tbl[t].base));
         chk($sformatf("vec%0d_lastbyte", t), 32'(got[tbl[t].exp_n - 1]),
             32'(tbl[t].base + 8'(tbl[t].len - 1)));
         chk($sformatf("vec%0d_busy", t), 32'(bus.busy), 32'(tbl[t].exp_busy));
      end

      // Two contenders, then a second req1 packet while req3 waits.
      do_reset();
      load_pkt(1, 2, 8'h10, 1'b1);
      load_pkt(2, 2, 8'h20, 1'b1);
      load_pkt(1, 2, 8'h18, 1'b1);
      load_pkt(3, 2, 8'h30, 1'b1);
      expq = '{8'hA1, 8'h10, 8'h11, 8'hA2, 8'h20, 8'h21,
               8'hA3, 8'h30, 8'h31, 8'hA1, 8'h18, 8'h19};
      run_until(12, 400, "rr");
      repeat (8) step();
      cmp_stream("rr");

      // 20-byte stream without last is cut at 16; req2 gets its turn in between.
      do_reset();
      load_pkt(0, 20, 8'h00, 1'b0);
      load_pkt(2, 2, 8'hC1, 1'b1);
      expq.delete();
      expq.push_back(8'hA0);
      for (int k = 0; k < 16; k++) expq.push_back(8'(k));
      expq.push_back(8'hA2); expq.push_back(8'hC1); expq.push_back(8'hC2);
      expq.push_back(8'hA0);
      for (int k = 16; k < 20; k++) expq.push_back(8'(k));
      run_until(25, 800, "cap");
      repeat (8) step();
      cmp_stream("cap");
      chk("cap_held", 32'(bus.busy), 32'd1);

      // Slow UART: txrdy stays high for 5 cycles after each write.
      do_reset();
      hold_cfg = 5;
      load_pkt(0, 2, 8'h44, 1'b1);
      expq = '{8'hA0, 8'h44, 8'h45};
      run_until(3, 200, "slow");
      repeat (12) step();
      cmp_stream("slow");
      for (int k = 1; k < wr_cyc.size(); k++)
         chk($sformatf("slow_gap%0d", k), 32'(wr_cyc[k] - wr_cyc[k-1] >= 7), 32'd1);

      // Granted requester pauses 10 cycles after two bytes; req3 must wait.
      do_reset();
      gap_id = 0; gap_after = 2; gap_rem = 10;
      load_pkt(0, 4, 8'h50, 1'b1);
      load_pkt(3, 2, 8'h70, 1'b1);
      expq = '{8'hA0, 8'h50, 8'h51, 8'h52, 8'h53, 8'hA3, 8'h70, 8'h71};
      run_until(8, 300, "pause");
      repeat (8) step();
      cmp_stream("pause");
      chk("pause_taken", 32'(gap_rem), 32'd0);

      // Reset while the second data byte of req2 is awaiting acknowledge.
      do_reset();
      load_pkt(1, 1, 8'hE0, 1'b1);
      load_pkt(2, 5, 8'h60, 1'b1);
      run_until(5, 200, "mid_rst");
      aresetn = 1'b0;
      #1;
      chk("mid_rst_tx_wr", 32'(bus.tx_wr), 32'd0);
      chk("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
      chk("mid_rst_grant", 32'(bus.grant_id), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      env_clear();
      repeat (3) step();
      aresetn = 1'b1;
      repeat (5) step();
      chk("mid_rst_no_wr", 32'(got.size()), 32'd0);
      load_pkt(3, 1, 8'hB0, 1'b1);
      load_pkt(1, 1, 8'hD0, 1'b1);
      expq = '{8'hA1, 8'hD0, 8'hA3, 8'hB0};
      run_until(4, 200, "post_rst");
      repeat (8) step();
      cmp_stream("post_rst");

      // Randomized traffic against the packet model.
      for (int r = 0; r < 3; r++) begin
         do_reset();
         rand_uart = 1'b1;
         rand_gaps = 1'b1;
         hold_cfg = int'($urandom_range(0, 2));
         for (int i = 0; i < NR; i++) begin
            int npk;
            npk = int'($urandom_range(0, 3));
            for (int p = 0; p < npk; p++)
               load_pkt(i, int'($urandom_range(1, 40)), 8'($urandom_range(0, 255)), 1'b1);
         end
         model(0);
         run_until(expq.size(), 40 * expq.size() + 200, $sformatf("rand%0d", r));
         repeat (10) step();
         cmp_stream($sformatf("rand%0d", r));
         chk($sformatf("rand%0d_idle", r), 32'(bus.busy), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
